// File: rtl/ldm_seq_pkg.sv
// Shared definitions for the LDM/STM multi-register transfer sequencer.
package ldm_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0]  R15_CODE  = 4'd15;
  localparam logic [31:0] WORD_STEP = 32'd4;

endpackage

// File: rtl/ldm_seq_if.sv
// Decode-stage request and per-beat memory/writeback signals of the LDM/STM sequencer.
interface ldm_seq_if;
  logic        i_start;
  logic [15:0] i_reg_list;
  logic        i_is_load;
  logic        i_p;
  logic        i_u;
  logic        i_w;
  logic [31:0] i_base;
  logic [3:0]  i_base_code;
  logic        i_flush;

  logic        o_ldm_hold;
  logic        o_mem_vld;
  logic [31:0] o_addr;
  logic [3:0]  o_rd_code;
  logic        o_is_load;
  logic        o_wb_base_vld;
  logic [31:0] o_wb_base_val;
  logic        o_done;

  modport master (
    output i_start, i_reg_list, i_is_load, i_p, i_u, i_w, i_base, i_base_code, i_flush,
    input  o_ldm_hold, o_mem_vld, o_addr, o_rd_code, o_is_load,
           o_wb_base_vld, o_wb_base_val, o_done
  );

  modport slave (
    input  i_start, i_reg_list, i_is_load, i_p, i_u, i_w, i_base, i_base_code, i_flush,
    output o_ldm_hold, o_mem_vld, o_addr, o_rd_code, o_is_load,
           o_wb_base_vld, o_wb_base_val, o_done
  );
endinterface

// File: rtl/ldm_prio_enc.sv
// Lowest-set-bit encoder with valid flag and population count over a 16-bit register list.
module ldm_prio_enc (
  input  logic [15:0] vec,
  output logic [3:0]  code,
  output logic        valid,
  output logic [4:0]  count
);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    code  = '0;
    count = '0;
    // Descending scan: the last hit written is the lowest set bit.
    for (int k = 15; k >= 0; k--) begin
      if (vec[k]) code = 4'(k);
    end
    for (int k = 0; k < 16; k++) begin
      count = count + 5'(vec[k]);
    end
  end

  assign valid = |vec;

endmodule

// File: rtl/ldm_seq.sv
// LDM/STM sequencer: expands one block-transfer instruction into per-register memory beats,
// an optional base writeback and a completion pulse, holding the pipeline meanwhile.
module ldm_seq
  import ldm_seq_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst_n,
  ldm_seq_if.slave bus
);

  state_t      state_q, state_d;
  logic [15:0] list_q;
  logic        is_load_q;
  logic        w_q;
  logic [3:0]  base_code_q;
  logic        base_hit_q;
  logic [31:0] addr_q;
  logic [31:0] wb_val_q;
  logic [31:0] last_addr_q;
  logic [3:0]  last_code_q;
  logic        last_is_load_q;

  logic [15:0] enc_in;
  logic [3:0]  cur_code;
  logic        enc_valid;
  logic [4:0]  enc_count;

  logic [31:0] base_al;
  logic [31:0] span;
  logic [31:0] start_addr;
  logic [31:0] wb_val;
  logic        start_ok;
  logic        beat;
  logic        last_beat;
  logic        wb_go;

  // In IDLE the encoder sizes the incoming list; afterwards it walks the latched one.
  assign enc_in = (state_q == ST_IDLE) ? bus.i_reg_list : list_q;

  ldm_prio_enc u_prio_enc (
    .vec   (enc_in),
    .code  (cur_code),
    .valid (enc_valid),
    .count (enc_count)
  );

  assign base_al = {bus.i_base[31:2], 2'b00};
  assign span    = {25'd0, enc_count, 2'b00};
  assign wb_val  = bus.i_u ? (base_al + span) : (base_al - span);

  always_comb begin
    start_addr = base_al;
    unique case ({bus.i_p, bus.i_u})
      2'b01:   start_addr = base_al;
      2'b11:   start_addr = base_al + WORD_STEP;
      2'b00:   start_addr = base_al - span + WORD_STEP;
      default: start_addr = base_al - span;
    endcase
  end

  assign start_ok  = (state_q == ST_IDLE) && bus.i_start && !bus.i_flush;
  assign beat      = (state_q == ST_XFER) && !bus.i_flush;
  assign last_beat = (enc_count == 5'd1);
  // A load that overwrites the base register owns it; writeback is dropped.
  assign wb_go     = w_q && !(is_load_q && (base_hit_q || (cur_code == base_code_q)));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.i_start) state_d = enc_valid ? ST_XFER : ST_DONE;
      ST_XFER: if (last_beat)   state_d = wb_go ? ST_WB : ST_DONE;
      ST_WB:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.i_flush) state_d = ST_IDLE;
  end

  // NOTE: datapath registers are reset too, so a reset mid-sequence clears every visible output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      list_q         <= '0;
      is_load_q      <= 1'b0;
      w_q            <= 1'b0;
      base_code_q    <= '0;
      base_hit_q     <= 1'b0;
      addr_q         <= '0;
      wb_val_q       <= '0;
      last_addr_q    <= '0;
      last_code_q    <= '0;
      last_is_load_q <= 1'b0;
    end else if (start_ok && enc_valid) begin
      list_q      <= bus.i_reg_list;
      is_load_q   <= bus.i_is_load;
      w_q         <= bus.i_w;
      base_code_q <= bus.i_base_code;
      base_hit_q  <= 1'b0;
      addr_q      <= start_addr;
      wb_val_q    <= wb_val;
    end else if (beat) begin
      list_q         <= list_q & ~(16'd1 << cur_code);
      addr_q         <= addr_q + WORD_STEP;
      last_addr_q    <= addr_q;
      last_code_q    <= cur_code;
      last_is_load_q <= is_load_q;
      if (cur_code == base_code_q) base_hit_q <= 1'b1;
    end
  end

  always_comb begin
    bus.o_mem_vld     = beat;
    bus.o_addr        = beat ? addr_q    : last_addr_q;
    bus.o_rd_code     = beat ? cur_code  : last_code_q;
    bus.o_is_load     = beat ? is_load_q : last_is_load_q;
    bus.o_wb_base_vld = (state_q == ST_WB) && !bus.i_flush;
    bus.o_wb_base_val = wb_val_q;
    bus.o_done        = (state_q == ST_DONE) && !bus.i_flush;
    // The start-cycle term is combinational so the pipeline stalls in the same cycle.
    bus.o_ldm_hold    = i_rst_n && !bus.i_flush &&
                        ((state_q == ST_XFER) || (state_q == ST_WB) ||
                         ((state_q == ST_IDLE) && bus.i_start && enc_valid));
  end

endmodule

// File: tb/tb_ldm_seq.sv
// Scoreboard bench for ldm_seq: expected beats/writebacks are queued at launch and
// popped as the sequencer emits them.
module tb_ldm_seq;
  import ldm_seq_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  code;
    logic        is_load;
  } beat_t;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;

  ldm_seq_if bus ();

  ldm_seq dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  beat_t       beat_q[$];
  logic [31:0] wb_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic idle_inputs();
    bus.i_start     = 1'b0;
    bus.i_reg_list  = '0;
    bus.i_is_load   = 1'b0;
    bus.i_p         = 1'b0;
    bus.i_u         = 1'b0;
    bus.i_w         = 1'b0;
    bus.i_base      = '0;
    bus.i_base_code = '0;
    bus.i_flush     = 1'b0;
  endtask

  task automatic launch(input logic [15:0] list, input logic ld, input logic p, input logic u,
                        input logic w, input logic [31:0] base, input logic [3:0] bcode);
    bus.i_reg_list  = list;
    bus.i_is_load   = ld;
    bus.i_p         = p;
    bus.i_u         = u;
    bus.i_w         = w;
    bus.i_base      = base;
    bus.i_base_code = bcode;
    bus.i_start     = 1'b1;
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [3:0] c, input logic ld);
    beat_t b;
    b.addr    = a;
    b.code    = c;
    b.is_load = ld;
    beat_q.push_back(b);
  endtask

  // Called just after a negedge with launch() applied; runs until o_done or a cycle budget.
  task automatic run_seq(input string name, input int exp_hold, input logic [31:0] exp_last_addr);
    int    holds;
    bit    got_done;
    beat_t exp;
    beat_t act;
    holds    = 0;
    got_done = 1'b0;
    #1;
    if (bus.o_ldm_hold) holds++;
    for (int cyc = 0; cyc < 40 && !got_done; cyc++) begin
      @(negedge i_clk);
      if (cyc == 0) bus.i_start = 1'b0;
      #1;
      if (bus.o_ldm_hold) holds++;
      if (bus.o_mem_vld) begin
        checks++;
        act = {bus.o_addr, bus.o_rd_code, bus.o_is_load};
        if (beat_q.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected beat addr=%h code=%0d", name, act.addr, act.code);
        end else begin
          exp = beat_q.pop_front();
          if (act !== exp) begin
            errors++;
            $display("FAIL %s beat got addr=%h code=%0d ld=%0b want addr=%h code=%0d ld=%0b",
                     name, act.addr, act.code, act.is_load, exp.addr, exp.code, exp.is_load);
          end
        end
      end
      if (bus.o_wb_base_vld) begin
        checks++;
        if (wb_q.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected writeback val=%h", name, bus.o_wb_base_val);
        end else if (bus.o_wb_base_val !== wb_q[0]) begin
          errors++;
          $display("FAIL %s writeback got %h want %h", name, bus.o_wb_base_val, wb_q[0]);
          void'(wb_q.pop_front());
        end else begin
          void'(wb_q.pop_front());
        end
      end
      if (bus.o_done) begin
        got_done = 1'b1;
        checks++;
        if (bus.o_mem_vld !== 1'b0 || bus.o_addr !== exp_last_addr) begin
          errors++;
          $display("FAIL %s done-cycle vld=%0b addr=%h want vld=0 addr=%h",
                   name, bus.o_mem_vld, bus.o_addr, exp_last_addr);
        end
      end
    end
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL %s no o_done within budget", name);
    end
    checks++;
    if (holds != exp_hold) begin
      errors++;
      $display("FAIL %s hold cycles got %0d want %0d", name, holds, exp_hold);
    end
    checks++;
    if (beat_q.size() != 0 || wb_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing events beats=%0d wbs=%0d", name, beat_q.size(), wb_q.size());
    end
    @(negedge i_clk);
    #1;
    checks++;
    if (bus.o_done !== 1'b0 || bus.o_ldm_hold !== 1'b0) begin
      errors++;
      $display("FAIL %s after-done got done=%0b hold=%0b want 0/0", name, bus.o_done, bus.o_ldm_hold);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    checks++;
    if ({bus.o_ldm_hold, bus.o_mem_vld, bus.o_addr, bus.o_rd_code, bus.o_is_load,
         bus.o_wb_base_vld, bus.o_wb_base_val, bus.o_done} !== '0) begin
      errors++;
      $display("FAIL reset outputs not zero addr=%h wbv=%h", bus.o_addr, bus.o_wb_base_val);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_ldmia_wb();
    push_beat(32'h0000_1000, 4'd1, 1'b1);
    push_beat(32'h0000_1004, 4'd3, 1'b1);
    wb_q.push_back(32'h0000_1008);
    launch(16'h000A, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_1000, 4'd0);
    run_seq("ldmia_wb", 4, 32'h0000_1004);
  endtask

  task automatic test_stmdb();
    push_beat(32'h0000_1FEC, 4'd4,  1'b0);
    push_beat(32'h0000_1FF0, 4'd5,  1'b0);
    push_beat(32'h0000_1FF4, 4'd6,  1'b0);
    push_beat(32'h0000_1FF8, 4'd7,  1'b0);
    push_beat(32'h0000_1FFC, 4'd14, 1'b0);
    wb_q.push_back(32'h0000_1FEC);
    launch(16'h40F0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2000, 4'd13);
    run_seq("stmdb", 7, 32'h0000_1FFC);
  endtask

  task automatic test_ldmib_r15_wrap();
    push_beat(32'h0000_0000, R15_CODE, 1'b1);
    launch(16'h8000, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 4'd2);
    run_seq("ldmib_r15", 2, 32'h0000_0000);
  endtask

  task automatic test_base_in_list();
    push_beat(32'h0000_0040, 4'd0, 1'b1);
    push_beat(32'h0000_0044, 4'd1, 1'b1);
    launch(16'h0003, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 4'd0);
    run_seq("base_in_list", 3, 32'h0000_0044);
  endtask

  task automatic test_empty_list();
    launch(16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0500, 4'd0);
    run_seq("empty_list", 0, 32'h0000_0044);
  endtask

  task automatic test_stmda_unaligned();
    push_beat(32'h0000_00FC, 4'd2, 1'b0);
    push_beat(32'h0000_0100, 4'd3, 1'b0);
    wb_q.push_back(32'h0000_00F8);
    launch(16'h000C, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0103, 4'd1);
    run_seq("stmda_unaligned", 4, 32'h0000_0100);
  endtask

  task automatic test_flush();
    launch(16'h001E, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 4'd0);
    @(negedge i_clk);
    bus.i_start = 1'b0;
    #1;
    checks++;
    if (bus.o_mem_vld !== 1'b1 || bus.o_addr !== 32'h0000_0100 || bus.o_rd_code !== 4'd1) begin
      errors++;
      $display("FAIL flush first beat got vld=%0b addr=%h code=%0d want 1/00000100/1",
               bus.o_mem_vld, bus.o_addr, bus.o_rd_code);
    end
    @(negedge i_clk);
    bus.i_flush = 1'b1;
    #1;
    checks++;
    if (bus.o_mem_vld !== 1'b0 || bus.o_ldm_hold !== 1'b0 || bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL flush cycle got vld=%0b hold=%0b done=%0b want 0/0/0",
               bus.o_mem_vld, bus.o_ldm_hold, bus.o_done);
    end
    @(negedge i_clk);
    bus.i_flush = 1'b0;
    #1;
    checks++;
    if (bus.o_mem_vld !== 1'b0 || bus.o_ldm_hold !== 1'b0 || bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL flush next got vld=%0b hold=%0b done=%0b want 0/0/0",
               bus.o_mem_vld, bus.o_ldm_hold, bus.o_done);
    end
    test_ldmia_wb();
  endtask

  task automatic test_flush_beats_start();
    launch(16'h0003, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0800, 4'd9);
    bus.i_flush = 1'b1;
    #1;
    checks++;
    if (bus.o_ldm_hold !== 1'b0) begin
      errors++;
      $display("FAIL flush_vs_start hold got %0b want 0", bus.o_ldm_hold);
    end
    @(negedge i_clk);
    bus.i_flush = 1'b0;
    bus.i_start = 1'b0;
    #1;
    checks++;
    if (bus.o_mem_vld !== 1'b0 || bus.o_ldm_hold !== 1'b0) begin
      errors++;
      $display("FAIL flush_vs_start next got vld=%0b hold=%0b want 0/0", bus.o_mem_vld, bus.o_ldm_hold);
    end
    @(negedge i_clk);
  endtask

  task automatic test_reset_mid_xfer();
    launch(16'h40F0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2000, 4'd13);
    @(negedge i_clk);
    bus.i_start = 1'b0;
    #1;
    checks++;
    if (bus.o_mem_vld !== 1'b1 || bus.o_addr !== 32'h0000_1FEC) begin
      errors++;
      $display("FAIL rst_mid first beat got vld=%0b addr=%h want 1/00001FEC", bus.o_mem_vld, bus.o_addr);
    end
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_ldm_hold, bus.o_mem_vld, bus.o_addr, bus.o_rd_code, bus.o_is_load,
         bus.o_wb_base_vld, bus.o_wb_base_val, bus.o_done} !== '0) begin
      errors++;
      $display("FAIL rst_mid outputs got vld=%0b hold=%0b addr=%h wbv=%h want all 0",
               bus.o_mem_vld, bus.o_ldm_hold, bus.o_addr, bus.o_wb_base_val);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    test_ldmia_wb();
  endtask

  initial begin
    test_reset();
    test_ldmia_wb();
    test_stmdb();
    test_ldmib_r15_wrap();
    test_base_in_list();
    test_empty_list();
    test_stmda_unaligned();
    test_flush();
    test_flush_beats_start();
    test_reset_mid_xfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
